// File: rtl/peripheral_mpi_wb_pkg.sv
// Shared types for the MPI Wishbone initiator: FSM state encoding and response status codes.
package peripheral_mpi_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    BUS,
    RDATA,
    RESP
  } state_t;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_BUS_ERR = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;

endpackage

// File: rtl/peripheral_mpi_wb_initiator.sv
// Wishbone classic initiator: turns one command into len single-beat cycles,
// streams write data in / read data out, and returns one status response.
module peripheral_mpi_wb_initiator
  import peripheral_mpi_wb_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic             cmd_we,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_incr,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [LEN_W-1:0] rsp_count,
  output logic [31:0]      wb_adr_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_nxt;
  logic             incr_q;
  logic [TO_W-1:0]  to_cnt;

  assign count_nxt = count_q + LEN_W'(1);
  assign rsp_count = count_q;

  // Every output is a register updated together with the state, so the
  // handshake signals always agree with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rsp_valid   <= 1'b0;
      rsp_status  <= STAT_OK;
      wb_adr_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_dat_o    <= '0;
      len_q       <= '0;
      count_q     <= '0;
      incr_q      <= 1'b0;
      to_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wb_adr_o   <= cmd_addr;
            wb_we_o    <= cmd_we;
            len_q      <= cmd_len;
            incr_q     <= cmd_incr;
            count_q    <= '0;
            rsp_status <= STAT_OK;
            cmd_ready  <= 1'b0;
            if (cmd_len == '0) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (cmd_we) begin
              wdata_ready <= 1'b1;
              state       <= WDATA;
            end else begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              to_cnt   <= '0;
              state    <= BUS;
            end
          end
        end
        WDATA: begin
          if (wdata_valid) begin
            wb_dat_o    <= wdata;
            wdata_ready <= 1'b0;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            to_cnt      <= '0;
            state       <= BUS;
          end
        end
        BUS: begin
          to_cnt <= to_cnt + TO_W'(1);
          // err dominates a simultaneous ack; the acked beat is not counted
          if (wb_err_i) begin
            rsp_status <= STAT_BUS_ERR;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (wb_ack_i) begin
            count_q  <= count_nxt;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (incr_q) wb_adr_o <= wb_adr_o + 32'd4;
            if (!wb_we_o) begin
              rdata       <= wb_dat_i;
              rdata_valid <= 1'b1;
              state       <= RDATA;
            end else if (count_nxt == len_q) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              wdata_ready <= 1'b1;
              state       <= WDATA;
            end
          end else if (to_cnt == TO_LAST) begin
            rsp_status <= STAT_TIMEOUT;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RDATA: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            if (count_q == len_q) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              to_cnt   <= '0;
              state    <= BUS;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
